// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI4-Lite definitions for the load/store path: response codes and
// the responder's channel state encodings.
package ysyx_23060203_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for 15 fixed cycles plus 3 random ones.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/ysyx_23060203_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), one shift per cycle, seeded on reset.
module ysyx_23060203_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clock) begin
        if (reset) q <= SEED;
        else       q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/ysyx_23060203_axi_sram.sv
// AXI4-Lite word-array responder with independent read/write channels and
// programmable (optionally pseudo-random) response latency.
module ysyx_23060203_axi_sram
    import ysyx_23060203_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH      = 1024,
    parameter int          RD_LAT     = 0,
    parameter int          WR_LAT     = 0,
    parameter bit          RAND_DELAY = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= ADDR_BASE) && (((a - ADDR_BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic [CNT_W-1:0] extra, rd_load, wr_load;

    ysyx_23060203_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:2];
    assign extra   = RAND_DELAY ? {{(CNT_W-2){1'b0}}, lfsr[1:0]} : '0;
    assign rd_load = CNT_W'(RD_LAT) + extra;
    assign wr_load = CNT_W'(WR_LAT) + extra;

    // ---------------- read channel ----------------
    rd_state_t        r_state, r_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr, r_cur_addr;
    logic             r_capture;

    always_ff @(posedge clock) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_next = (rd_load == '0) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_cnt <= CNT_W'(1)) r_next = R_RESP;
            R_RESP:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid  = (r_state == R_RESP);
    end

    // The address is taken straight from the bus when the wait is skipped.
    assign r_cur_addr = (r_state == R_IDLE) ? araddr : r_addr;
    assign r_capture  = (r_state != R_RESP) && (r_next == R_RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_addr <= '0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                r_addr <= araddr;
                r_cnt  <= rd_load;
            end else if (r_state == R_WAIT) begin
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            if (r_capture) begin
                rdata <= in_range(r_cur_addr) ? mem[to_idx(r_cur_addr)] : 32'h0;
                rresp <= in_range(r_cur_addr) ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t        w_state, w_next;
    logic [CNT_W-1:0] w_cnt;
    logic [31:0]      w_addr, w_data;
    logic [3:0]       w_strb;
    logic             aw_got, w_got, aw_take, w_take, both;
    logic [31:0]      w_cur_addr, w_cur_data;
    logic [3:0]       w_cur_strb;
    logic             commit;

    assign aw_take = (w_state == W_IDLE) && !aw_got && awvalid;
    assign w_take  = (w_state == W_IDLE) && !w_got && wvalid;
    assign both    = (aw_got || aw_take) && (w_got || w_take);

    always_ff @(posedge clock) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (both) w_next = (wr_load == '0) ? W_RESP : W_WAIT;
            W_WAIT:  if (w_cnt <= CNT_W'(1)) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state == W_IDLE) && !aw_got;
        wready  = (w_state == W_IDLE) && !w_got;
        bvalid  = (w_state == W_RESP);
    end

    // A beat arriving on the completing edge bypasses its holding register.
    assign w_cur_addr = aw_got ? w_addr : awaddr;
    assign w_cur_data = w_got  ? w_data : wdata;
    assign w_cur_strb = w_got  ? w_strb : wstrb;
    assign commit     = (w_state != W_RESP) && (w_next == W_RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            w_cnt  <= '0;
            w_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            bresp  <= RESP_OKAY;
        end else begin
            if (aw_take) begin
                w_addr <= awaddr;
                aw_got <= 1'b1;
            end
            if (w_take) begin
                w_data <= wdata;
                w_strb <= wstrb;
                w_got  <= 1'b1;
            end
            if (w_state == W_IDLE && both) w_cnt <= wr_load;
            else if (w_state == W_WAIT)    w_cnt <= w_cnt - CNT_W'(1);
            if (commit) bresp <= in_range(w_cur_addr) ? RESP_OKAY : RESP_DECERR;
            if (w_state == W_RESP && bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    // Storage is not reset; a reset edge also suppresses any pending commit.
    always_ff @(posedge clock) begin
        if (!reset && commit && in_range(w_cur_addr)) begin
            for (int b = 0; b < 4; b++)
                if (w_cur_strb[b]) mem[to_idx(w_cur_addr)][8*b +: 8] <= w_cur_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_axi_sram.sv
// Self-checking bench: two responders (fixed latency / random latency) driven
// by directed and $urandom traffic, checked against a byte-merge memory model.
module tb_ysyx_23060203_axi_sram;

    localparam int          N    = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr [N];
    logic        arvalid[N];
    logic        arready[N];
    logic [31:0] rdata  [N];
    logic [1:0]  rresp  [N];
    logic        rvalid [N];
    logic        rready [N];
    logic [31:0] awaddr [N];
    logic        awvalid[N];
    logic        awready[N];
    logic [31:0] wdata  [N];
    logic [3:0]  wstrb  [N];
    logic        wvalid [N];
    logic        wready [N];
    logic [1:0]  bresp  [N];
    logic        bvalid [N];
    logic        bready [N];

    logic [31:0] mref [N][1024];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_23060203_axi_sram #(.RD_LAT(0), .WR_LAT(2), .RAND_DELAY(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]));

    ysyx_23060203_axi_sram #(.RD_LAT(1), .WR_LAT(1), .RAND_DELAY(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]));

    // Latency window per instance: fixed latency + 1, plus up to 3 random cycles.
    function automatic int rd_lo(input int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int rd_hi(input int d); return (d == 0) ? 1 : 5; endfunction
    function automatic int wr_lo(input int d); return (d == 0) ? 3 : 2; endfunction
    function automatic int wr_hi(input int d); return (d == 0) ? 3 : 5; endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic bit mapped(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) / 4 < 1024);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic axi_write(input int d, input logic [31:0] a, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int k = 0;
        resp = 2'b01;
        lat  = 0;
        bready[d] = 1'b0;
        while (!(aw_done && w_done) && k < 100) begin
            awvalid[d] = !aw_done && (k >= aw_dly);
            wvalid[d]  = !w_done && (k >= w_dly);
            awaddr[d]  = aw_done ? $urandom : a;
            wdata[d]   = w_done ? $urandom : data;
            wstrb[d]   = w_done ? 4'($urandom) : strb;
            hs_aw = awvalid[d] && awready[d];
            hs_w  = wvalid[d] && wready[d];
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            k++;
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'(aw_done && w_done), 1);
            return;
        end
        lat = 1;
        bready[d] = 1'b1;
        while (!bvalid[d] && lat < 100) begin
            tick();
            lat++;
        end
        if (!bvalid[d]) begin
            check("bvalid_timeout", 32'(bvalid[d]), 1);
            bready[d] = 1'b0;
            return;
        end
        resp = bresp[d];
        tick();
        bready[d] = 1'b0;
    endtask

    task automatic axi_read(input int d, input logic [31:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int k = 0;
        data = 32'hx;
        resp = 2'b01;
        lat  = 0;
        rready[d]  = 1'b0;
        araddr[d]  = a;
        arvalid[d] = 1'b1;
        while (!arready[d] && k < 100) begin
            tick();
            k++;
        end
        if (!arready[d]) begin
            check("arready_timeout", 32'(arready[d]), 1);
            arvalid[d] = 1'b0;
            return;
        end
        tick();
        arvalid[d] = 1'b0;
        araddr[d]  = $urandom;
        lat = 1;
        while (!rvalid[d] && lat < 100) begin
            check("ar_busy", 32'(arready[d]), 0);
            tick();
            lat++;
        end
        if (!rvalid[d]) begin
            check("rvalid_timeout", 32'(rvalid[d]), 1);
            return;
        end
        data = rdata[d];
        resp = rresp[d];
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_rvalid", 32'(rvalid[d]), 1);
            check("hold_rdata", rdata[d], data);
            check("hold_arready", 32'(arready[d]), 0);
        end
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
        check("arready_back", 32'(arready[d]), 1);
    endtask

    // Write through the DUT and mirror the effect in the model.
    task automatic mwrite(input int d, input logic [31:0] a, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
        logic [1:0] resp;
        int lat;
        axi_write(d, a, data, strb, aw_dly, w_dly, resp, lat);
        check("bresp", 32'(resp), mapped(a) ? 32'h0 : 32'h3);
        check("wr_lat", 32'(lat), 32'(clamp(lat, wr_lo(d), wr_hi(d))));
        if (mapped(a)) mref[d][widx(a)] = merge(mref[d][widx(a)], data, strb);
    endtask

    task automatic mread(input int d, input logic [31:0] a, input int hold);
        logic [31:0] data;
        logic [1:0]  resp;
        int lat;
        axi_read(d, a, hold, data, resp, lat);
        check("rresp", 32'(resp), mapped(a) ? 32'h0 : 32'h3);
        check("rdata", data, mapped(a) ? mref[d][widx(a)] : 32'h0);
        check("rd_lat", 32'(lat), 32'(clamp(lat, rd_lo(d), rd_hi(d))));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, data;
        logic [1:0]  resp;
        int lat;

        reset = 1'b1;
        for (int d = 0; d < N; d++) begin
            araddr[d] = '0; arvalid[d] = 0; rready[d] = 0;
            awaddr[d] = '0; awvalid[d] = 0; wdata[d] = '0; wstrb[d] = '0;
            wvalid[d] = 0; bready[d] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        for (int d = 0; d < N; d++) begin
            check("rst_arready", 32'(arready[d]), 1);
            check("rst_awready", 32'(awready[d]), 1);
            check("rst_wready", 32'(wready[d]), 1);
            check("rst_rvalid", 32'(rvalid[d]), 0);
            check("rst_bvalid", 32'(bvalid[d]), 0);
            check("rst_rdata", rdata[d], 0);
            check("rst_rresp", 32'(rresp[d]), 0);
            check("rst_bresp", 32'(bresp[d]), 0);
        end

        // Basic write then read-back, zero read latency.
        axi_write(0, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
        check("t1_bresp", 32'(resp), 0);
        check("t1_wlat", 32'(lat), 3);
        mref[0][4] = 32'hDEADBEEF;
        axi_read(0, 32'h8000_0010, 0, data, resp, lat);
        check("t1_rdata", data, 32'hDEADBEEF);
        check("t1_rresp", 32'(resp), 0);
        check("t1_rlat", 32'(lat), 1);

        // Byte strobes.
        mwrite(0, 32'h8000_0020, 32'h11223344, 4'hF, 0, 0);
        mwrite(0, 32'h8000_0020, 32'hAABBCCDD, 4'b0101, 1, 0);
        axi_read(0, 32'h8000_0020, 0, data, resp, lat);
        check("t2_strb", data, 32'h11BB33DD);

        // AW three cycles after W: latency counts from the AW handshake.
        axi_write(0, 32'h8000_0030, 32'h12345678, 4'hF, 3, 0, resp, lat);
        check("t3_wlat", 32'(lat), 3);
        check("t3_bresp", 32'(resp), 0);
        mref[0][12] = 32'h12345678;
        mread(0, 32'h8000_0030, 0);

        // Out-of-range decode must not alias onto the edge words.
        mwrite(0, 32'h8000_0000, 32'hA5A5_0000, 4'hF, 0, 0);
        mwrite(0, 32'h8000_0FFC, 32'h0000_5A5A, 4'hF, 0, 0);
        mread(0, 32'h7FFF_FFFC, 0);
        mread(0, 32'h8000_1000, 0);
        mwrite(0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0);
        mwrite(0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        mread(0, 32'h8000_0000, 0);
        mread(0, 32'h8000_0FFC, 0);

        // Random latency with a stalled master.
        mwrite(1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 0);
        mread(1, 32'h8000_0040, 5);

        // Reset while both channels are waiting.
        araddr[1] = 32'h8000_0040; arvalid[1] = 1;
        awaddr[1] = 32'h8000_0040; awvalid[1] = 1;
        wdata[1] = 32'h5555_5555; wstrb[1] = 4'hF; wvalid[1] = 1;
        tick();
        arvalid[1] = 0; awvalid[1] = 0; wvalid[1] = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_rvalid", 32'(rvalid[1]), 0);
        check("mid_rst_bvalid", 32'(bvalid[1]), 0);
        check("mid_rst_arready", 32'(arready[1]), 1);
        check("mid_rst_awready", 32'(awready[1]), 1);
        check("mid_rst_wready", 32'(wready[1]), 1);
        repeat (6) tick();
        check("mid_rst_no_r", 32'(rvalid[1]), 0);
        check("mid_rst_no_b", 32'(bvalid[1]), 0);
        mread(1, 32'h8000_0040, 0);

        // Randomized traffic on both instances.
        for (int d = 0; d < N; d++) begin
            for (int w = 0; w < 16; w++)
                mwrite(d, BASE + 32'(4 * w), $urandom, 4'hF, 0, 0);
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(7) == 0)
                    a = $urandom_range(1) ? BASE + 32'h1000 + 32'(4 * $urandom_range(63))
                                          : BASE - 32'd4 - 32'(4 * $urandom_range(63));
                else
                    a = BASE + 32'(4 * $urandom_range(15)) + 32'($urandom_range(3));
                if ($urandom_range(1) == 0)
                    mwrite(d, a, $urandom, 4'($urandom), $urandom_range(3), $urandom_range(3));
                else
                    mread(d, a, $urandom_range(3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_axi_sram.md
# ysyx_23060203_axi_sram

AXI4-Lite memory responder (slave) that terminates the load/store master port of the execute stage. It serves the read channels (AR/R) and write channels (AW/W/B) independently from an internal word array, with programmable and optionally pseudo-random response latency. The latency is there to stress the master's valid/ready handling in simulation and small FPGA builds.

## Interface
Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH, 1024, number of 32-bit words (power of two)
- RD_LAT, 0, fixed extra read latency in cycles (0–15)
- WR_LAT, 0, fixed extra write latency in cycles (0–15)
- RAND_DELAY, 0, when 1, add 0–3 pseudo-random cycles per transaction

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address accepted
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  master accepts read data
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bresp  out  2  write response: 00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  master accepts write response

## Operation
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE drives arready=1. The AR handshake latches araddr and loads cnt=RD_LAT+extra.
  - If cnt==0 at the handshake, the FSM goes directly to R_RESP. Otherwise it goes to R_WAIT and decrements cnt each cycle; at cnt==0 it moves to R_RESP.
  - On entry to R_RESP, rdata/rresp are registered from the array. rvalid is held with stable data until rready is seen, then the FSM returns to R_IDLE.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - In W_IDLE, awready=1 until AW is latched and wready=1 until W is latched. AW and W are accepted in either order or in the same cycle.
  - Once both are held, cnt=WR_LAT+extra is loaded. The FSM waits as in the read FSM, then commits the write on the edge into W_RESP.
  - The commit writes only the bytes with wstrb bit set. bvalid is held until bready, then the FSM returns to W_IDLE.
- Decode: index = (addr − ADDR_BASE)>>2. addr[1:0] is ignored.
  - Out of range means addr < ADDR_BASE or index ≥ DEPTH. The response is then DECERR; a read returns rdata=0 and a write leaves the array unmodified.
- Random delay: a 16-bit LFSR (seed 16'hACE1 at reset) advances every cycle. extra = lfsr[1:0] sampled at load time if RAND_DELAY=1, else 0.
- Read and write run concurrently. If a write commit and a read capture hit the same word on the same edge, the read returns the old data.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. Both FSMs go to IDLE, cnt=0, LFSR=seed.
- Array contents are not reset.
- Read latency: rvalid rises RD_LAT+extra+1 cycles after the AR handshake edge. With RD_LAT=0 and no random delay, rvalid is high in the cycle after the handshake.
- Write latency: bvalid rises WR_LAT+extra+1 cycles after the later of the AW/W handshake edges.
- At most one outstanding read and one outstanding write.
  - arready=0 from the handshake until the R handshake completes.
  - awready/wready deassert individually once their beat is latched.
- Back-to-back: arready returns to 1 the cycle after the rvalid&rready edge. There is no combinational path from rready to arready.
- A reset asserted mid-transaction abandons it: no response is issued and a pending write is not committed.

## Structure
- Package ysyx_23060203_axi_pkg holds RESP_OKAY/RESP_DECERR constants and the read/write state enums. The execute-side load/store unit imports the same package.
- One sub-module, ysyx_23060203_lfsr16: a Galois LFSR with taps 16,14,13,11, one shift per cycle, seeded on reset.
- Storage is an inferred register array of DEPTH×32.

## Test plan
- Write 32'hDEADBEEF to 0x8000_0010 (wstrb=4'hF), then read it back -> bresp=00 and rdata=32'hDEADBEEF, rresp=00. With RD_LAT=0, rvalid appears 1 cycle after the AR handshake.
- Preload 32'h11223344, then write wdata=32'hAABBCCDD with wstrb=4'b0101 -> a later read returns 32'h11BB33DD.
- AW presented 3 cycles after W, WR_LAT=2 -> bvalid rises 3 cycles after the AW handshake, and the write is committed exactly once.
- Read 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> rresp=11 with rdata=0. Writing the same addresses gives bresp=11 and leaves the array unchanged.
- Hold rready=0 for 5 cycles with RAND_DELAY=1 -> rvalid and rdata stay stable, arready stays 0, and read-to-rvalid delay lies in [RD_LAT+1, RD_LAT+4].
- Assert reset while in R_WAIT and W_WAIT -> next cycle rvalid=bvalid=0 and all ready signals=1; the target word keeps its old value.
